// File: rtl/regfile_clr_pkg.sv
// Shared constants and state encoding for the clearing register file.
package regfile_clr_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;
  localparam int unsigned RegNumLog2 = 5;

  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam logic RstEnable   = 1'b1;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  typedef enum logic {
    RfStClear = 1'b0,
    RfStRun   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/clear/$0 masking, write bypass, array read.
module regfile_rd_port
  import regfile_clr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegBus,
  parameter int unsigned ADDR_WIDTH = RegAddrBus
) (
  input  logic                  rst,
  input  logic                  clearing,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] arr_data,
  output logic [DATA_WIDTH-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (rst == RstEnable) begin
      rdata = '0;
    end else if (clearing) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
    end else if (re == ReadEnable && we == WriteEnable && raddr == waddr) begin
      // The write only lands at the next edge, so forward it now.
      rdata = wdata;
    end else if (re == ReadEnable) begin
      rdata = arr_data;
    end
  end

endmodule

// File: rtl/regfile_clr.sv
// Register file with hardwired $0, same-cycle bypass and a post-reset clear sequencer.
module regfile_clr
  import regfile_clr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegBus,
  parameter int unsigned ADDR_WIDTH = RegAddrBus,
  parameter int unsigned NUM_REGS   = RegNum
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  busy_o
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  rf_state_e             st_q, st_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic                  clearing;

  assign clearing = (st_q == RfStClear);
  assign busy_o   = busy_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      st_q      <= RfStClear;
      clr_cnt_q <= ADDR_WIDTH'(1);
      busy_q    <= 1'b1;
    end else begin
      st_q      <= st_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    unique case (st_q)
      RfStClear: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
          st_d   = RfStRun;
          busy_d = 1'b0;
        end
      end
      RfStRun: begin
        st_d = RfStRun;
      end
      default: begin
        st_d = RfStClear;
      end
    endcase
  end

  // Reset leaves the array alone; the clear sequence zeroes it instead. Writes during
  // clear are dropped, and $0 is never written (counter starts at 1, waddr 0 blocked).
  always_ff @(posedge clk) begin
    if (rst != RstEnable) begin
      if (clearing) begin
        regs[clr_cnt_q] <= '0;
      end else if (we == WriteEnable && waddr != '0) begin
        regs[waddr] <= wdata;
      end
    end
  end

  regfile_rd_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_port1 (
    .rst      (rst),
    .clearing (clearing),
    .re       (re1),
    .raddr    (raddr1),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .arr_data (regs[raddr1]),
    .rdata    (rdata1)
  );

  regfile_rd_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_port2 (
    .rst      (rst),
    .clearing (clearing),
    .re       (re2),
    .raddr    (raddr2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .arr_data (regs[raddr2]),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_regfile_clr.sv
// Scoreboard-driven bench for regfile_clr: clear sequence, write/read, bypass, $0, restarts.
module tb_regfile_clr;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        busy_o;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] model[32];

  regfile_clr dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Counts edges while busy_o is high, starting from a negedge; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] port_model(input logic re, input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (re && we && ra == waddr) return wdata;
    if (re) return model[ra];
    return 32'h0;
  endfunction

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 1", busy_o);
    end
    we = 1'b1; waddr = 5'd3; wdata = 32'h11112222;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL reset_rd1: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL reset_rd2: got %h expected %h", rdata2, e); end
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL clear_rd1: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL clear_rd2: got %h expected %h", rdata2, e); end
    idle();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic test_first_clear();
    int n;
    count_busy(n);
    checks++;
    if (n != 31) begin failures++; $display("FAIL first_clear_len: got %0d expected 31", n); end
  endtask

  task automatic test_clear_preloaded();
    logic [31:0] e;
    int n;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(i); wdata = 32'hDEADBEEF;
    end
    @(negedge clk);
    idle();
    re1 = 1'b1; raddr1 = 5'd9;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL preload: got %h expected %h", rdata1, e); end
    idle();
    pulse_rst();
    count_busy(n);
    checks++;
    if (n != 31) begin failures++; $display("FAIL clear_len: got %0d expected 31", n); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      re1 = 1'b1; raddr1 = 5'(i); re2 = 1'b1; raddr2 = 5'(31 - i);
      exp_q.push_back(model[i]); exp_q.push_back(model[31 - i]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin failures++; $display("FAIL cleared_rd1[%0d]: got %h expected %h", i, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin failures++; $display("FAIL cleared_rd2[%0d]: got %h expected %h", 31 - i, rdata2, e); end
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234ABCD;
    @(negedge clk);
    model[5] = 32'h1234ABCD;
    idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd5;
    exp_q.push_back(32'h1234ABCD); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL write_read_rd1: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL write_read_rd2_disabled: got %h expected %h", rdata2, e); end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'hCAFEF00D;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hCAFEF00D);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL bypass_rd1: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL bypass_rd2: got %h expected %h", rdata2, e); end
    @(negedge clk);
    model[7] = 32'hCAFEF00D;
    we = 1'b0;
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hCAFEF00D);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL bypass_array_rd1: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL bypass_array_rd2: got %h expected %h", rdata2, e); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] e;
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL zero_bypass_rd1: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL zero_bypass_rd2: got %h expected %h", rdata2, e); end
    @(negedge clk);
    we = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL zero_after_edge: got %h expected %h", rdata1, e); end
    idle();
  endtask

  task automatic test_write_during_clear();
    logic [31:0] e;
    pulse_rst();
    for (int edge_n = 1; edge_n <= 31; edge_n++) begin
      idle();
      if (edge_n == 10 || edge_n == 25) begin
        we = 1'b1; waddr = 5'd20; wdata = 32'h55;
        re1 = 1'b1; raddr1 = 5'd20;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin failures++; $display("FAIL clear_write_rd1[%0d]: got %h expected %h", edge_n, rdata1, e); end
      end
      @(negedge clk);
    end
    idle();
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL clear_write_busy_end: got %b expected 0", busy_o); end
    re1 = 1'b1; raddr1 = 5'd20; re2 = 1'b1; raddr2 = 5'd5;
    exp_q.push_back(model[20]); exp_q.push_back(model[5]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin failures++; $display("FAIL clear_write_dropped: got %h expected %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin failures++; $display("FAIL clear_rezeroed_r5: got %h expected %h", rdata2, e); end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] e;
    int n;
    for (int i = 28; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(i); wdata = 32'hA5A50000 | i;
    end
    @(negedge clk);
    idle();
    pulse_rst();
    for (int edge_n = 1; edge_n < 15; edge_n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_clear_busy: got %b expected 1", busy_o); end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n != 31) begin failures++; $display("FAIL mid_clear_len: got %0d expected 31", n); end
    for (int i = 0; i < 32; i += 2) begin
      @(negedge clk);
      re1 = 1'b1; raddr1 = 5'(i); re2 = 1'b1; raddr2 = 5'(i + 1);
      exp_q.push_back(model[i]); exp_q.push_back(model[i + 1]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin failures++; $display("FAIL restart_rd1[%0d]: got %h expected %h", i, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin failures++; $display("FAIL restart_rd2[%0d]: got %h expected %h", i + 1, rdata2, e); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      re1 = 1'($urandom_range(0, 3) != 0);
      raddr1 = 5'($urandom_range(0, 7));
      re2 = 1'($urandom_range(0, 3) != 0);
      raddr2 = (c % 3 == 0) ? waddr : 5'($urandom_range(0, 7));
      exp_q.push_back(port_model(re1, raddr1));
      exp_q.push_back(port_model(re2, raddr2));
      #1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin failures++; $display("FAIL b2b_rd1[%0d]: got %h expected %h", c, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin failures++; $display("FAIL b2b_rd2[%0d]: got %h expected %h", c, rdata2, e); end
      if (we && waddr != 5'd0) model[waddr] = wdata;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_first_clear();
    test_clear_preloaded();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_write_during_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_clr.md
Name: regfile_clr

Overview:
- General-purpose register file that answers the decode stage's two read requests and accepts the write-back stage's single write.
- Sits between write-back (wb) and decode (id) in the five-stage pipeline.
- Provides same-cycle write-to-read bypass and a hardwired $0.
- After reset, a clear sequencer zeroes every register, so no instruction ever reads X.

Parameters:
- DATA_WIDTH, 32, register width (`RegBus).
- ADDR_WIDTH, 5, register address width (`RegAddrBus).
- NUM_REGS, 32, register count; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high (`RstEnable = 1'b1).
- we  in  1  write enable from wb.
- waddr  in  ADDR_WIDTH  write register address.
- wdata  in  DATA_WIDTH  write data.
- re1  in  1  read-port-1 enable (decode reg1_read).
- raddr1  in  ADDR_WIDTH  read-port-1 address.
- rdata1  out  DATA_WIDTH  read-port-1 data, combinational.
- re2  in  1  read-port-2 enable.
- raddr2  in  ADDR_WIDTH  read-port-2 address.
- rdata2  out  DATA_WIDTH  read-port-2 data, combinational.
- busy_o  out  1  high while the clear sequencer runs; registered.

Behaviour:
- State machine: CLEAR, RUN. Registered state st, clear counter clr_cnt[ADDR_WIDTH-1:0].
- Reset, sampled at a clk edge with rst=1:
  - st<=CLEAR, clr_cnt<=1, busy_o<=1.
  - Register array contents are not touched by reset itself.
  - busy_o reset value is 1.
- CLEAR, each edge with rst=0:
  - regs[clr_cnt]<=0; clr_cnt<=clr_cnt+1.
  - At clr_cnt==NUM_REGS-1, also st<=RUN and busy_o<=0.
  - Result: busy_o is high for exactly NUM_REGS-1 (31) edges after rst deasserts; the first RUN edge is the 32nd.
- CLEAR, other rules:
  - we is ignored: the write is dropped, not queued. wb must not issue writes while busy_o=1; the pipeline is stalled by busy_o.
  - rst reasserted mid-CLEAR restarts: clr_cnt<=1.
- RUN:
  - At an edge, if we=1 and waddr!=0: regs[waddr]<=wdata.
  - Writes to address 0 are discarded.
  - rst in RUN re-enters CLEAR and re-zeroes everything.
- Read port n (identical for n=1,2), combinational priority:
  1. rst=1 -> 0.
  2. st==CLEAR -> 0.
  3. raddrn==0 -> 0.
  4. ren=1 and we=1 and raddrn==waddr -> wdata (bypass; the write lands at the next edge).
  5. ren=1 -> regs[raddrn].
  6. otherwise -> 0.
- Read latency: zero cycles (combinational). Write latency: visible through the array one edge after issue, and via bypass in the same cycle.
- Both ports may address the same register; both return the same value, including the bypass case.
- $0 is never written: CLEAR starts at 1, and RUN blocks waddr==0.
- regs[0] storage is unused; implementation may omit it.

Decomposition:
- defines.v holds:
  - RegBus, RegAddrBus, RegNum (32), RegNumLog2 (5).
  - WriteEnable, ReadEnable, RstEnable, ZeroWord, NOPRegAddr.
  - New constants RF_ST_CLEAR and RF_ST_RUN.
- One sub-module, regfile_rd_port, is natural: the priority mux plus bypass compare, instanced twice.
- Storage, write logic and the clear FSM stay in the top.

Test Plan:
- Clear sequence: pulse rst for 1 cycle -> busy_o=1 for exactly 31 edges after release. Every register then reads 0x00000000, including ones preloaded with 0xDEADBEEF before reset.
- Basic write/read: we=1, waddr=5, wdata=0x1234ABCD for one edge. Next cycle re1=1, raddr1=5 -> rdata1=0x1234ABCD. rdata2 with re2=0 -> 0.
- Bypass: same cycle we=1, waddr=7, wdata=0xCAFEF00D, re1=re2=1, raddr1=raddr2=7 -> both ports 0xCAFEF00D combinationally. After the edge, they still read 0xCAFEF00D from the array.
- $0: we=1, waddr=0, wdata=0xFFFFFFFF, re1=1, raddr1=0 -> rdata1=0 in the same cycle and after the edge.
- Write during CLEAR: at the 10th busy edge, we=1, waddr=20, wdata=0x55 -> dropped. After busy_o falls, raddr1=20 reads 0.
- Reset mid-clear: reassert rst on the 15th busy edge -> busy_o stays 1 and the count restarts: 31 further edges after release, then all registers read 0.
